rocc_lat_acc: RTL and testbench

ROCC_LAT_ACC -- requirements
Module: rocc_lat_acc

---
 rtl/rocc_lat_pkg.sv | 20 ++
 rtl/rocc_cmd_fifo.sv | 41 ++++
 rtl/rocc_lat_acc.sv | 147 ++++++++++++++
 tb/tb_rocc_lat_acc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_lat_pkg.sv
// Shared types for the latency-programmable RoCC accelerator: FSM states,
// the SETLAT opcode and the queued-command header layout.
package rocc_lat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [6:0] SETLAT_FUNCT = 7'h7F;

  // Queued command header; rs1/rs2 follow it in the FIFO entry.
  typedef struct packed {
    logic [6:0] funct;
    logic [4:0] rd;
    logic       xd;
  } cmd_hdr_t;

endpackage

// File: rtl/rocc_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers and full/empty flags.
module rocc_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_c = mem_q[rd_q[AW-1:0]];
  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/rocc_lat_acc.sv
// RoCC accelerator with a programmable per-funct latency table: commands are
// queued, executed one at a time for L cycles, and optionally answered.
module rocc_lat_acc
  import rocc_lat_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_FUNCT   = 8,
  parameter int unsigned LAT_WIDTH   = 16,
  parameter int unsigned DEFAULT_LAT = 500
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [6:0]      cmd_funct,
  input  logic [4:0]      cmd_rd,
  input  logic            cmd_xd,
  input  logic [XLEN-1:0] cmd_rs1,
  input  logic [XLEN-1:0] cmd_rs2,
  input  logic            resp_ready,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int unsigned IDX_W = (NUM_FUNCT > 1) ? $clog2(NUM_FUNCT) : 1;
  localparam int unsigned HDR_W = $bits(cmd_hdr_t);
  localparam int unsigned ENT_W = HDR_W + 2 * XLEN;

  state_e               state_q;
  logic                 ready_q;
  logic                 xd_q;
  logic [LAT_WIDTH-1:0] cnt_q;
  logic [LAT_WIDTH-1:0] lat_q [NUM_FUNCT];
  logic                 resp_valid_q;
  logic [4:0]           resp_rd_q;
  logic [XLEN-1:0]      resp_data_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENT_W-1:0]     fifo_wdata;
  logic [ENT_W-1:0]     fifo_rdata;

  cmd_hdr_t             head_hdr;
  logic [XLEN-1:0]      head_rs1;
  logic [XLEN-1:0]      head_rs2;
  logic                 is_setlat;
  logic                 set_in_range;
  logic                 funct_in_range;
  logic [IDX_W-1:0]     set_idx;
  logic [IDX_W-1:0]     funct_idx;
  logic [LAT_WIDTH-1:0] eff_lat;
  logic [XLEN-1:0]      result;

  assign cmd_ready  = ready_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_wdata = {cmd_funct, cmd_rd, cmd_xd, cmd_rs1, cmd_rs2};
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;

  rocc_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Decode the head entry: effective latency and response payload.
  always_comb begin
    head_hdr       = fifo_rdata[ENT_W-1 -: HDR_W];
    head_rs1       = fifo_rdata[2*XLEN-1 -: XLEN];
    head_rs2       = fifo_rdata[XLEN-1:0];
    is_setlat      = (head_hdr.funct == SETLAT_FUNCT);
    set_in_range   = (head_rs1 < XLEN'(NUM_FUNCT));
    funct_in_range = (32'(head_hdr.funct) < NUM_FUNCT);
    set_idx        = IDX_W'(head_rs1);
    funct_idx      = IDX_W'(head_hdr.funct);
    eff_lat        = funct_in_range ? lat_q[funct_idx] : LAT_WIDTH'(DEFAULT_LAT);
    if (is_setlat) eff_lat = LAT_WIDTH'(1);
    if (eff_lat == '0) eff_lat = LAT_WIDTH'(1);
    if (is_setlat) result = set_in_range ? XLEN'(lat_q[set_idx]) : '0;
    else           result = head_rs1 + head_rs2;
  end

  // Execution FSM; table write and response capture happen at the pop edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      xd_q         <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      for (int i = 0; i < NUM_FUNCT; i++) lat_q[i] <= LAT_WIDTH'(DEFAULT_LAT);
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q     <= ST_RUN;
            cnt_q       <= eff_lat - LAT_WIDTH'(1);
            xd_q        <= head_hdr.xd;
            resp_rd_q   <= head_hdr.rd;
            resp_data_q <= result;
            if (is_setlat && set_in_range) lat_q[set_idx] <= LAT_WIDTH'(head_rs2);
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            if (xd_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - LAT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rocc_lat_acc.sv
// Bench for rocc_lat_acc: latency vector table, back-pressure, xd=0 and
// mid-run reset sequences, with a response scoreboard.
module tb_rocc_lat_acc;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [6:0]  SETLAT     = 7'h7F;

  logic            clock;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [6:0]      cmd_funct;
  logic [4:0]      cmd_rd;
  logic            cmd_xd;
  logic [XLEN-1:0] cmd_rs1;
  logic [XLEN-1:0] cmd_rs2;
  logic            resp_ready;
  logic            resp_valid;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  rocc_lat_acc dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_funct  (cmd_funct),
    .cmd_rd     (cmd_rd),
    .cmd_xd     (cmd_xd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  typedef struct {
    logic [6:0]      funct;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    int unsigned     lat;
    logic [XLEN-1:0] data;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) begin
      @(posedge clock); #1;
    end
    if (busy) fail_bound("wait_idle");
  endtask

  // Returns after the accepting edge (+1); pushes the expected response.
  task automatic send(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] want);
    cmd_funct = f; cmd_rd = rd; cmd_xd = xd; cmd_rs1 = a; cmd_rs2 = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !cmd_ready; i++) begin
      @(posedge clock); #1;
    end
    if (!cmd_ready) fail_bound("send_ready");
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    if (xd) exp_q.push_back('{rd, want});
  endtask

  task automatic wait_resp(output int k);
    k = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (!resp_valid && k < 2000);
  endtask

  task automatic drive_fill(input int n);
    cmd_funct = 7'd0; cmd_rd = 5'(20 + n); cmd_xd = 1'b1;
    cmd_rs1 = XLEN'(n); cmd_rs2 = XLEN'(100);
    cmd_valid = 1'b1;
  endtask

  initial begin
    int  k;
    int  n;
    int  hits;
    bit  acc;
    bit  dropped;
    exp_t e;

    checks = 0; errors = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_funct = '0; cmd_rd = '0; cmd_xd = 1'b0;
    cmd_rs1 = '0; cmd_rs2 = '0; resp_ready = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (reset && resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rd %0d data %0h, want none", resp_rd, resp_data);
          end else if (resp_ready) begin
            e = exp_q.pop_front();
            chk("sb_resp_rd", 64'(resp_rd), 64'(e.rd));
            chk("sb_resp_data", resp_data, e.data);
          end
        end
      end
    join_none

    // funct, rd, rs1, rs2, latency, response data
    vecs[0]  = '{7'd0,   5'd3,  64'd5,  64'd6,  500, 64'd11};
    vecs[1]  = '{SETLAT, 5'd1,  64'd2,  64'd10, 1,   64'd500};
    vecs[2]  = '{7'd2,   5'd2,  64'd7,  64'd8,  10,  64'd15};
    vecs[3]  = '{SETLAT, 5'd4,  64'd1,  64'd3,  1,   64'd500};
    vecs[4]  = '{SETLAT, 5'd5,  64'd3,  64'd0,  1,   64'd500};
    vecs[5]  = '{SETLAT, 5'd6,  64'd0,  64'd1,  1,   64'd500};
    vecs[6]  = '{SETLAT, 5'd7,  64'd1,  64'd7,  1,   64'd3};
    vecs[7]  = '{7'd1,   5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 7, 64'd1};
    vecs[8]  = '{7'd3,   5'd9,  64'd100, 64'd23, 1,  64'd123};
    vecs[9]  = '{7'd0,   5'd10, 64'hDEAD, 64'd1, 1,  64'hDEAE};
    vecs[10] = '{SETLAT, 5'd11, 64'd9,  64'd5,  1,   64'd0};
    vecs[11] = '{7'd9,   5'd12, 64'd1,  64'd1,  500, 64'd2};
    vecs[12] = '{7'd100, 5'd13, 64'd2,  64'd2,  500, 64'd4};
    vecs[13] = '{SETLAT, 5'd14, 64'd2,  64'h1_0004, 1, 64'd10};
    vecs[14] = '{7'd2,   5'd15, 64'd0,  64'd0,  4,   64'd0};
    vecs[15] = '{SETLAT, 5'd16, 64'h1_0000_0002, 64'd9, 1, 64'd0};
    vecs[16] = '{7'd2,   5'd17, 64'd3,  64'd4,  4,   64'd7};
    vecs[17] = '{SETLAT, 5'd18, 64'd7,  64'd2,  1,   64'd500};
    vecs[18] = '{7'd7,   5'd19, 64'd10, 64'd20, 2,   64'd30};
    vecs[19] = '{SETLAT, 5'd20, 64'd8,  64'd3,  1,   64'd0};

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rd", 64'(resp_rd), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clock); #1;
    chk("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

    // Latency/data table: response L+1 cycles after accept, held one cycle
    for (int i = 0; i < 20; i++) begin
      wait_idle();
      send(vecs[i].funct, vecs[i].rd, 1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].data);
      wait_resp(k);
      chk($sformatf("vec%0d_latency", i), 64'(k), 64'(vecs[i].lat + 1));
      @(posedge clock); #1;
      chk($sformatf("vec%0d_hold", i), 64'(resp_valid), 64'd0);
    end

    // Back-pressure: funct 0 has L=1; one command is popped, four fill the FIFO
    wait_idle();
    resp_ready = 1'b0;
    n = 0;
    drive_fill(0);
    for (int c = 0; c < 10; c++) begin
      acc = cmd_ready && (n < 6);
      @(posedge clock); #1;
      if (acc) begin
        exp_q.push_back('{5'(20 + n), XLEN'(100 + n)});
        n++;
        if (n < 6) drive_fill(n); else cmd_valid = 1'b0;
      end
    end
    chk("fill_accepts", 64'(n), 64'(FIFO_DEPTH + 1));
    chk("fill_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("fill_resp_valid", 64'(resp_valid), 64'd1);
    chk("fill_resp_rd", 64'(resp_rd), 64'd20);
    chk("fill_resp_data", resp_data, 64'd100);
    resp_ready = 1'b1;
    for (int c = 0; c < 200 && n < 6; c++) begin
      acc = cmd_ready && (n < 6);
      @(posedge clock); #1;
      if (acc) begin
        exp_q.push_back('{5'(20 + n), XLEN'(100 + n)});
        n++;
        if (n < 6) drive_fill(n); else cmd_valid = 1'b0;
      end
    end
    chk("fill_all_accepted", 64'(n), 64'd6);
    wait_idle();
    @(posedge clock); #1;
    chk("fill_drained", 64'(exp_q.size()), 64'd0);

    // xd=0 (funct 1, L=7) then xd=1 (funct 0, L=1): one response, busy throughout
    send(7'd1, 5'd29, 1'b0, 64'd40, 64'd2, 64'd42);
    chk("xd0_busy", 64'(busy), 64'd1);
    send(7'd0, 5'd30, 1'b1, 64'd1, 64'd2, 64'd3);
    dropped = 1'b0;
    k = 0;
    do begin
      if (!busy) dropped = 1'b1;
      @(posedge clock); #1;
      k++;
    end while (!resp_valid && k < 200);
    chk("xd_seq_latency", 64'(k), 64'd9);
    chk("xd_seq_busy_held", 64'(dropped), 64'd0);
    @(posedge clock); #1;
    chk("xd_seq_busy_final", 64'(busy), 64'd0);
    chk("xd_seq_valid_final", 64'(resp_valid), 64'd0);

    // Reset 20 cycles into RUN with two commands queued
    send(7'd9, 5'd1, 1'b1, 64'd1, 64'd1, 64'd2);
    send(7'd0, 5'd2, 1'b1, 64'd2, 64'd2, 64'd4);
    send(7'd0, 5'd3, 1'b1, 64'd3, 64'd3, 64'd6);
    repeat (18) @(posedge clock);
    #1 chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("midrun_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrun_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrun_resp_rd", 64'(resp_rd), 64'd0);
    chk("midrun_resp_data", resp_data, 64'd0);
    chk("midrun_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clock);
    #4 reset = 1'b1;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (resp_valid || busy) hits++;
    end
    chk("post_reset_silent", 64'(hits), 64'd0);
    send(SETLAT, 5'd4, 1'b1, 64'd2, 64'd6, 64'd500);
    wait_resp(k);
    chk("table_restored_lat", 64'(k), 64'd2);
    wait_idle();
    send(SETLAT, 5'd5, 1'b1, 64'd7, 64'd6, 64'd500);
    wait_resp(k);
    wait_idle();
    @(posedge clock); #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
